// File: rtl/t5_wback.sv
// Writeback stage: picks ALU, link or load data for the GPRF write port and
// holds a load in WAIT (stalling upstream) until the data bus acknowledges.
module t5_wback #(
  parameter int unsigned XLEN = 32
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            xval,
  input  logic [1:0]      xhart,
  input  logic            xwre,
  input  logic [4:0]      xrd,
  input  logic [1:0]      xsel,
  input  logic [1:0]      xlsz,
  input  logic            xlsx,
  input  logic [1:0]      xadr,
  input  logic [XLEN-1:0] malu,
  input  logic [XLEN-1:0] mpc,
  input  logic [XLEN-1:0] dwb_dti,
  input  logic            dwb_ack,
  output logic            mwre,
  output logic [1:0]      mhart,
  output logic [4:0]      rd0a,
  output logic [XLEN-1:0] rd0d,
  output logic            wstall
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state;
  logic [1:0]      l_hart;
  logic            l_wre;
  logic [4:0]      l_rd;
  logic [1:0]      l_lsz;
  logic            l_lsx;
  logic [1:0]      l_adr;
  logic            is_load;
  logic [XLEN-1:0] idle_data;

  // Little-endian lane select plus sign/zero extension.
  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] d,
                                                 input logic [1:0] sz,
                                                 input logic sx,
                                                 input logic [1:0] adr);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = d[{adr, 3'b000} +: 8];
    h = d[{adr[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{(XLEN-8){sx & b[7]}}, b};
      2'b01:   r = {{(XLEN-16){sx & h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign is_load = (xsel == 2'b10);

  always_comb begin
    idle_data = malu;
    case (xsel)
      2'b01:   idle_data = mpc;
      2'b10:   idle_data = align_load(dwb_dti, xlsz, xlsx, xadr);
      default: idle_data = malu;
    endcase
  end

  assign wstall = sena & ~srst &
                  (((state == StIdle) & xval & is_load & ~dwb_ack) |
                   ((state == StWait) & ~dwb_ack));

  always_ff @(posedge sclk) begin
    if (srst) begin
      state  <= StIdle;
      mwre   <= 1'b0;
      mhart  <= 2'b00;
      rd0a   <= 5'd0;
      rd0d   <= '0;
      l_hart <= 2'b00;
      l_wre  <= 1'b0;
      l_rd   <= 5'd0;
      l_lsz  <= 2'b00;
      l_lsx  <= 1'b0;
      l_adr  <= 2'b00;
    end else if (sena) begin
      mwre <= 1'b0;
      case (state)
        StIdle: begin
          if (xval) begin
            if (!is_load || dwb_ack) begin
              mwre  <= xwre & (xrd != 5'd0);
              mhart <= xhart;
              rd0a  <= xrd;
              rd0d  <= idle_data;
            end else begin
              l_hart <= xhart;
              l_wre  <= xwre;
              l_rd   <= xrd;
              l_lsz  <= xlsz;
              l_lsx  <= xlsx;
              l_adr  <= xadr;
              state  <= StWait;
            end
          end
        end
        StWait: begin
          // Incoming x* are ignored here; only the latched load context is used.
          if (dwb_ack) begin
            mwre  <= l_wre & (l_rd != 5'd0);
            mhart <= l_hart;
            rd0a  <= l_rd;
            rd0d  <= align_load(dwb_dti, l_lsz, l_lsx, l_adr);
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_t5_wback.sv
// Directed bench for t5_wback: ALU/link/load selection, alignment, wait,
// enable hold and reset-in-wait behaviour.
module tb_t5_wback;

  logic        sclk = 1'b0;
  logic        srst, sena, xval, xwre, xlsx, dwb_ack;
  logic [1:0]  xhart, xsel, xlsz, xadr;
  logic [4:0]  xrd;
  logic [31:0] malu, mpc, dwb_dti;
  logic        mwre, wstall;
  logic [1:0]  mhart;
  logic [4:0]  rd0a;
  logic [31:0] rd0d;

  int n_cmp = 0;
  int n_err = 0;

  t5_wback #(.XLEN(32)) dut (
    .sclk(sclk), .srst(srst), .sena(sena), .xval(xval), .xhart(xhart),
    .xwre(xwre), .xrd(xrd), .xsel(xsel), .xlsz(xlsz), .xlsx(xlsx), .xadr(xadr),
    .malu(malu), .mpc(mpc), .dwb_dti(dwb_dti), .dwb_ack(dwb_ack),
    .mwre(mwre), .mhart(mhart), .rd0a(rd0a), .rd0d(rd0d), .wstall(wstall)
  );

  always #5 sclk = ~sclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // Single-cycle load with ack present; checks the aligned result.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic sx,
                         input logic [1:0] adr, input logic [31:0] exp);
    xval = 1; xsel = 2'b10; xwre = 1; xrd = 5'd7; xhart = 2'd0;
    xlsz = sz; xlsx = sx; xadr = adr; dwb_ack = 1; dwb_dti = 32'h80FF_7F01;
    #1;
    check_eq({tag, "_stall"}, {31'd0, wstall}, 32'd0);
    step();
    check_eq(tag, rd0d, exp);
    check_eq({tag, "_we"}, {31'd0, mwre}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    srst = 1; sena = 1; xval = 1; xhart = 0; xwre = 1; xrd = 0; xsel = 2'b10;
    xlsz = 0; xlsx = 0; xadr = 0; malu = 0; mpc = 0; dwb_dti = 0; dwb_ack = 0;
    #1;
    check_eq("rst_stall", {31'd0, wstall}, 32'd0);
    step(); step();
    check_eq("rst_mwre", {31'd0, mwre}, 32'd0);
    check_eq("rst_mhart", {30'd0, mhart}, 32'd0);
    check_eq("rst_rd0a", {27'd0, rd0a}, 32'd0);
    check_eq("rst_rd0d", rd0d, 32'd0);
    srst = 0; xval = 0;

    // T1 ALU
    xval = 1; xsel = 2'b00; xrd = 5'd5; xhart = 2'd2; xwre = 1; malu = 32'h1234_5678;
    step();
    check_eq("t1_mwre", {31'd0, mwre}, 32'd1);
    check_eq("t1_mhart", {30'd0, mhart}, 32'd2);
    check_eq("t1_rd0a", {27'd0, rd0a}, 32'd5);
    check_eq("t1_rd0d", rd0d, 32'h1234_5678);
    xval = 0; malu = 32'hDEAD_0000;
    step();
    check_eq("t1_idle_mwre", {31'd0, mwre}, 32'd0);
    check_eq("t1_idle_rd0d", rd0d, 32'h1234_5678);

    // T2 link and x0
    xval = 1; xsel = 2'b01; mpc = 32'h100; xrd = 5'd1; xhart = 2'd0; malu = 32'h5555;
    step();
    check_eq("t2_rd0d", rd0d, 32'h100);
    check_eq("t2_mwre", {31'd0, mwre}, 32'd1);
    xrd = 5'd0; mpc = 32'h200;
    step();
    check_eq("t2_x0_mwre", {31'd0, mwre}, 32'd0);
    check_eq("t2_x0_rd0a", {27'd0, rd0a}, 32'd0);
    check_eq("t2_x0_rd0d", rd0d, 32'h200);

    // T3 alignment
    do_load("lb3", 2'b00, 1'b1, 2'd3, 32'hFFFF_FF80);
    do_load("lbu1", 2'b00, 1'b0, 2'd1, 32'h0000_007F);
    do_load("lh2", 2'b01, 1'b1, 2'd2, 32'hFFFF_80FF);
    do_load("lhu0", 2'b01, 1'b0, 2'd0, 32'h0000_7F01);
    do_load("lw", 2'b10, 1'b1, 2'd1, 32'h80FF_7F01);

    // T4 wait for ack; x inputs change during WAIT and must be ignored
    xval = 1; xsel = 2'b10; xwre = 1; xrd = 5'd9; xhart = 2'd3; xlsz = 2'b10;
    dwb_ack = 0; dwb_dti = 32'hCAFE_BABE;
    #1;
    check_eq("t4_stall_c1", {31'd0, wstall}, 32'd1);
    step();
    check_eq("t4_mwre_c1", {31'd0, mwre}, 32'd0);
    check_eq("t4_rd0a_hold", {27'd0, rd0a}, 32'd7);
    xrd = 5'd4; xhart = 2'd1; xlsz = 2'b00; xsel = 2'b00;
    for (int i = 2; i <= 3; i++) begin
      #1;
      check_eq($sformatf("t4_stall_c%0d", i), {31'd0, wstall}, 32'd1);
      step();
      check_eq($sformatf("t4_mwre_c%0d", i), {31'd0, mwre}, 32'd0);
    end
    dwb_ack = 1;
    #1;
    check_eq("t4_stall_ack", {31'd0, wstall}, 32'd0);
    step();
    check_eq("t4_mwre", {31'd0, mwre}, 32'd1);
    check_eq("t4_rd0a", {27'd0, rd0a}, 32'd9);
    check_eq("t4_mhart", {30'd0, mhart}, 32'd3);
    check_eq("t4_rd0d", rd0d, 32'hCAFE_BABE);
    xval = 0; dwb_ack = 0;
    step();
    check_eq("t4_pulse", {31'd0, mwre}, 32'd0);

    // T5 sena=0 during WAIT
    xval = 1; xsel = 2'b10; xwre = 1; xrd = 5'd10; xhart = 2'd1; xlsz = 2'b00;
    xlsx = 0; xadr = 2'd2; dwb_ack = 0; dwb_dti = 32'h00AB_0000;
    step();
    sena = 0; dwb_ack = 1; xval = 0;
    #1;
    check_eq("t5_stall_off", {31'd0, wstall}, 32'd0);
    step(); step();
    check_eq("t5_hold_mwre", {31'd0, mwre}, 32'd0);
    check_eq("t5_hold_rd0a", {27'd0, rd0a}, 32'd9);
    sena = 1; dwb_ack = 0;
    #1;
    check_eq("t5_still_wait", {31'd0, wstall}, 32'd1);
    step();
    dwb_ack = 1;
    step();
    check_eq("t5_mwre", {31'd0, mwre}, 32'd1);
    check_eq("t5_rd0a", {27'd0, rd0a}, 32'd10);
    check_eq("t5_rd0d", rd0d, 32'h0000_00AB);
    check_eq("t5_mhart", {30'd0, mhart}, 32'd1);
    dwb_ack = 0;
    step();

    // T6 reset while waiting
    xval = 1; xsel = 2'b10; xrd = 5'd11; xhart = 2'd2; xlsz = 2'b10; dwb_ack = 0;
    step();
    xval = 0; srst = 1;
    #1;
    check_eq("t6_stall_rst", {31'd0, wstall}, 32'd0);
    step();
    srst = 0;
    check_eq("t6_mwre", {31'd0, mwre}, 32'd0);
    check_eq("t6_rd0a", {27'd0, rd0a}, 32'd0);
    check_eq("t6_rd0d", rd0d, 32'd0);
    dwb_ack = 1; dwb_dti = 32'h1111_2222;
    #1;
    check_eq("t6_stall", {31'd0, wstall}, 32'd0);
    step();
    check_eq("t6_late_ack", {31'd0, mwre}, 32'd0);
    check_eq("t6_late_rd0d", rd0d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
